// File: rtl/cal_view_pkg.sv
// Shared types, month table and small weekday helpers for the calendar view controller.
//   weekday_t      : 0=MON .. 6=SUN
//   month_t        : 0=Jan .. 11=Dec
//   DAYS_IN_MONTH  : non-leap day counts
//   leap_fix()     : day count with February corrected for leap years
//   wday_add()     : 3-bit weekday addition modulo 7
package cal_view_pkg;

    localparam int unsigned YEAR_W = 12;

    typedef enum logic [2:0] {MON, TUE, WED, THU, FRI, SAT, SUN} weekday_t;

    typedef logic [3:0] month_t;

    typedef enum logic [1:0] {ReqNone, ReqToday, ReqPrev, ReqNext} req_e;

    localparam logic [4:0] DAYS_IN_MONTH [12] = '{
        5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
        5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
    };

    function automatic logic [4:0] leap_fix(input month_t month, input logic leap);
        logic [4:0] d;
        d = 5'd31;
        if (month < 4'd12) d = DAYS_IN_MONTH[month];
        if (month == 4'd1 && leap) d = 5'd29;
        return d;
    endfunction

    // Compare-and-subtract keeps the result in 0..6 without a divider.
    function automatic logic [2:0] wday_add(input logic [2:0] wd, input logic [2:0] inc);
        logic [3:0] s;
        s = {1'b0, wd} + {1'b0, inc};
        if (s >= 4'd7) s = s - 4'd7;
        return s[2:0];
    endfunction

endpackage

// File: rtl/cal_first_day_calc.sv
// Iterative first-weekday engine. Starting from the anchor year it walks one year per cycle up
// to the target year, then one month per cycle up to the target month.
//   clk_i, rst_ni         : clock, async active-low reset
//   start_i               : launch (accepted only when idle), samples year_i / month_i
//   done_o                : one-cycle pulse when the result is ready
//   first_day_o           : weekday of the 1st of the target month (0=Mon)
//   days_cnt_o            : days in the target month
module cal_first_day_calc
    import cal_view_pkg::*;
#(
    parameter int unsigned YEAR_MIN    = 2000,
    parameter int unsigned ANCHOR_WDAY = 5,
    parameter int unsigned YEAR_W      = cal_view_pkg::YEAR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [YEAR_W-1:0] year_i,
    input  month_t            month_i,
    output logic              done_o,
    output logic [2:0]        first_day_o,
    output logic [4:0]        days_cnt_o
);

    typedef enum logic [1:0] {StIdle, StYears, StMonths} eng_state_e;

    eng_state_e        state_q, state_d;
    logic [YEAR_W-1:0] yr_q, yr_d, tgt_year_q, tgt_year_d;
    month_t            m_q, m_d, tgt_month_q, tgt_month_d;
    logic [2:0]        wd_q, wd_d;
    logic [1:0]        mod4_q, mod4_d;
    logic [6:0]        mod100_q, mod100_d;
    logic [8:0]        mod400_q, mod400_d;
    logic              leap_q, leap_d;
    logic              leap;
    logic [4:0]        dim_excess;

    // Counters track yr mod 4/100/400; valid because the anchor year is a multiple of 400.
    assign leap       = (mod4_q == 2'd0) && ((mod100_q != 7'd0) || (mod400_q == 9'd0));
    // 28..31 mod 7 is simply dim - 28.
    assign dim_excess = leap_fix(m_q, leap_q) - 5'd28;

    always_comb begin
        state_d     = state_q;
        yr_d        = yr_q;
        tgt_year_d  = tgt_year_q;
        m_d         = m_q;
        tgt_month_d = tgt_month_q;
        wd_d        = wd_q;
        mod4_d      = mod4_q;
        mod100_d    = mod100_q;
        mod400_d    = mod400_q;
        leap_d      = leap_q;
        done_o      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    yr_d        = YEAR_W'(YEAR_MIN);
                    wd_d        = 3'(ANCHOR_WDAY);
                    m_d         = 4'd0;
                    mod4_d      = 2'd0;
                    mod100_d    = 7'd0;
                    mod400_d    = 9'd0;
                    tgt_year_d  = year_i;
                    tgt_month_d = month_i;
                    state_d     = StYears;
                end
            end
            StYears: begin
                if (yr_q < tgt_year_q) begin
                    wd_d     = wday_add(wd_q, leap ? 3'd2 : 3'd1);
                    yr_d     = yr_q + YEAR_W'(1);
                    mod4_d   = mod4_q + 2'd1;
                    mod100_d = (mod100_q == 7'd99) ? 7'd0 : mod100_q + 7'd1;
                    mod400_d = (mod400_q == 9'd399) ? 9'd0 : mod400_q + 9'd1;
                end else begin
                    leap_d  = leap;
                    m_d     = 4'd0;
                    state_d = StMonths;
                end
            end
            StMonths: begin
                if (m_q < tgt_month_q) begin
                    wd_d = wday_add(wd_q, dim_excess[2:0]);
                    m_d  = m_q + 4'd1;
                end else begin
                    done_o  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            yr_q        <= YEAR_W'(YEAR_MIN);
            tgt_year_q  <= YEAR_W'(YEAR_MIN);
            m_q         <= 4'd0;
            tgt_month_q <= 4'd0;
            wd_q        <= 3'(ANCHOR_WDAY);
            mod4_q      <= 2'd0;
            mod100_q    <= 7'd0;
            mod400_q    <= 9'd0;
            leap_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            yr_q        <= yr_d;
            tgt_year_q  <= tgt_year_d;
            m_q         <= m_d;
            tgt_month_q <= tgt_month_d;
            wd_q        <= wd_d;
            mod4_q      <= mod4_d;
            mod100_q    <= mod100_d;
            mod400_q    <= mod400_d;
            leap_q      <= leap_d;
        end
    end

    assign first_day_o = wd_q;
    assign days_cnt_o  = leap_fix(tgt_month_q, leap_q);

endmodule

// File: rtl/cal_view_ctrl.sv
// Calendar view controller: navigation (prev/next/today), live-date follow, a single-entry
// pending request slot, and a frame-synchronous commit of the per-month render parameters.
// Optional build macro CAL_VIEW_WRAP_EN: prev/next wrap between YEAR_MIN/Jan and YEAR_MAX/Dec
// instead of clamping.
//   clk_25_i, rst_n_i               : pixel clock, async active-low reset
//   cur_year_i/month_i/day_i        : synchronised live date
//   prev_i, next_i, today_i         : single-cycle navigation pulses
//   frame_start_i                   : vertical-blank pulse, the only point where outputs change
//   view_year_o, view_month_o       : committed view month
//   month_first_day_o, month_days_cnt_o : weekday of the 1st, days in month
//   hl_day_o                        : live day when the view shows the live month, else 0
//   busy_o                          : computation or commit pending
module cal_view_ctrl
    import cal_view_pkg::*;
#(
    parameter int unsigned YEAR_MIN    = 2000,
    parameter int unsigned YEAR_MAX    = 2199,
    parameter int unsigned ANCHOR_WDAY = 5,
    parameter int unsigned YEAR_W      = cal_view_pkg::YEAR_W
) (
    input  logic              clk_25_i,
    input  logic              rst_n_i,
    input  logic [YEAR_W-1:0] cur_year_i,
    input  logic [3:0]        cur_month_i,
    input  logic [4:0]        cur_day_i,
    input  logic              prev_i,
    input  logic              next_i,
    input  logic              today_i,
    input  logic              frame_start_i,
    output logic [YEAR_W-1:0] view_year_o,
    output logic [3:0]        view_month_o,
    output logic [2:0]        month_first_day_o,
    output logic [4:0]        month_days_cnt_o,
    output logic [4:0]        hl_day_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {StIdle, StCalc, StWait, StCommit} ctrl_state_e;

    localparam logic [YEAR_W-1:0] YearMin = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] YearMax = YEAR_W'(YEAR_MAX);

    ctrl_state_e       state_q, state_d;
    logic [YEAR_W-1:0] tgt_year_q, tgt_year_d, view_year_q, view_year_d;
    month_t            tgt_month_q, tgt_month_d, view_month_q, view_month_d;
    logic [2:0]        first_day_q, first_day_d;
    logic [4:0]        days_q, days_d, hl_q, hl_d;
    logic              follow_q, follow_d, init_q;
    req_e              pend_q, pend_d, in_req, act_req;

    logic              nav_ok, nav_follow;
    logic [YEAR_W-1:0] nav_year;
    month_t            nav_month;
    logic              calc_start, calc_done;
    logic [2:0]        calc_first_day;
    logic [4:0]        calc_days;

    // Decode this cycle's request and resolve the new target relative to the current target.
    always_comb begin
        in_req = ReqNone;
        if (today_i || init_q ||
            (follow_q && ((cur_year_i != tgt_year_q) || (cur_month_i != tgt_month_q)))) begin
            in_req = ReqToday;
        end else if (prev_i && !next_i) begin
            in_req = ReqPrev;
        end else if (next_i && !prev_i) begin
            in_req = ReqNext;
        end
        act_req = (in_req != ReqNone) ? in_req : pend_q;

        nav_ok     = 1'b0;
        nav_year   = tgt_year_q;
        nav_month  = tgt_month_q;
        nav_follow = follow_q;
        case (act_req)
            ReqToday: begin
                nav_ok     = 1'b1;
                nav_year   = cur_year_i;
                nav_month  = cur_month_i;
                nav_follow = 1'b1;
            end
            ReqPrev: begin
                nav_follow = 1'b0;
                if (tgt_month_q != 4'd0) begin
                    nav_ok    = 1'b1;
                    nav_month = tgt_month_q - 4'd1;
                end else if (tgt_year_q != YearMin) begin
                    nav_ok    = 1'b1;
                    nav_year  = tgt_year_q - YEAR_W'(1);
                    nav_month = 4'd11;
`ifdef CAL_VIEW_WRAP_EN
                end else begin
                    nav_ok    = 1'b1;
                    nav_year  = YearMax;
                    nav_month = 4'd11;
`endif
                end
            end
            ReqNext: begin
                nav_follow = 1'b0;
                if (tgt_month_q != 4'd11) begin
                    nav_ok    = 1'b1;
                    nav_month = tgt_month_q + 4'd1;
                end else if (tgt_year_q != YearMax) begin
                    nav_ok    = 1'b1;
                    nav_year  = tgt_year_q + YEAR_W'(1);
                    nav_month = 4'd0;
`ifdef CAL_VIEW_WRAP_EN
                end else begin
                    nav_ok    = 1'b1;
                    nav_year  = YearMin;
                    nav_month = 4'd0;
`endif
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        tgt_year_d   = tgt_year_q;
        tgt_month_d  = tgt_month_q;
        follow_d     = follow_q;
        pend_d       = pend_q;
        view_year_d  = view_year_q;
        view_month_d = view_month_q;
        first_day_d  = first_day_q;
        days_d       = days_q;
        calc_start   = 1'b0;
        hl_d         = ((view_year_q == cur_year_i) && (view_month_q == cur_month_i)) ?
                       cur_day_i : 5'd0;
        unique case (state_q)
            StIdle: begin
                // A request that resolves to a clamp is dropped, including a pending one.
                pend_d = ReqNone;
                if (nav_ok) begin
                    tgt_year_d  = nav_year;
                    tgt_month_d = nav_month;
                    follow_d    = nav_follow;
                    calc_start  = 1'b1;
                    state_d     = StCalc;
                end
            end
            StCalc: if (calc_done) state_d = StWait;
            StWait: if (frame_start_i) state_d = StCommit;
            StCommit: begin
                view_year_d  = tgt_year_q;
                view_month_d = tgt_month_q;
                first_day_d  = calc_first_day;
                days_d       = calc_days;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Last request while busy wins; it launches from StIdle after the commit.
        if (state_q != StIdle && in_req != ReqNone) pend_d = in_req;
    end

    always_ff @(posedge clk_25_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= StIdle;
            tgt_year_q   <= YearMin;
            tgt_month_q  <= 4'd0;
            follow_q     <= 1'b1;
            pend_q       <= ReqNone;
            init_q       <= 1'b1;
            view_year_q  <= YearMin;
            view_month_q <= 4'd0;
            first_day_q  <= 3'(ANCHOR_WDAY);
            days_q       <= 5'd31;
            hl_q         <= 5'd0;
        end else begin
            state_q      <= state_d;
            tgt_year_q   <= tgt_year_d;
            tgt_month_q  <= tgt_month_d;
            follow_q     <= follow_d;
            pend_q       <= pend_d;
            init_q       <= 1'b0;
            view_year_q  <= view_year_d;
            view_month_q <= view_month_d;
            first_day_q  <= first_day_d;
            days_q       <= days_d;
            hl_q         <= hl_d;
        end
    end

    cal_first_day_calc #(
        .YEAR_MIN    (YEAR_MIN),
        .ANCHOR_WDAY (ANCHOR_WDAY),
        .YEAR_W      (YEAR_W)
    ) u_calc (
        .clk_i       (clk_25_i),
        .rst_ni      (rst_n_i),
        .start_i     (calc_start),
        .year_i      (nav_year),
        .month_i     (nav_month),
        .done_o      (calc_done),
        .first_day_o (calc_first_day),
        .days_cnt_o  (calc_days)
    );

    assign view_year_o       = view_year_q;
    assign view_month_o      = view_month_q;
    assign month_first_day_o = first_day_q;
    assign month_days_cnt_o  = days_q;
    assign hl_day_o          = hl_q;
    assign busy_o            = (state_q != StIdle) || (pend_q != ReqNone);

endmodule
